// File: rtl/countdown_timer_pkg.sv
// Shared types and defaults for the prescaled countdown timer controller.
// Optional feature macro used by the controller: COUNTDOWN_AUTO_RELOAD_EN.
package countdown_timer_pkg;

    localparam int DEFAULT_TICK_DIV   = 51;
    localparam int DEFAULT_TIMER_W    = 4;
    localparam int DEFAULT_INIT_VALUE = 9;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_RUN_ENC   = 2'd1;
    localparam logic [1:0] ST_PAUSE_ENC = 2'd2;
    localparam logic [1:0] ST_DONE_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_RUN   = ST_RUN_ENC,
        ST_PAUSE = ST_PAUSE_ENC,
        ST_DONE  = ST_DONE_ENC
    } state_t;

endpackage

// File: rtl/countdown_timer_ctrl_if.sv
// Control/status bundle between the game logic (master) and the timer controller (slave).
interface countdown_timer_ctrl_if #(
    parameter int TIMER_W = countdown_timer_pkg::DEFAULT_TIMER_W
);
    import countdown_timer_pkg::*;

    logic               start;
    logic               pause;
    logic               resume;
    logic               abort;
    logic               load_en;
    logic [TIMER_W-1:0] load_value;
    logic [TIMER_W-1:0] timer;
    logic               tick;
    logic               expired;
    logic               done;
    state_t             state;

    modport master (
        output start, pause, resume, abort, load_en, load_value,
        input  timer, tick, expired, done, state
    );

    modport slave (
        input  start, pause, resume, abort, load_en, load_value,
        output timer, tick, expired, done, state
    );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running modulo-TICK_DIV counter; tick_next flags that the coming edge wraps it.
module tick_prescaler #(
    parameter int TICK_DIV = countdown_timer_pkg::DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    input  logic clr,
    output logic tick_next
);

    localparam int               CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: sequential state is written with non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + ONE;
        end
    end

    assign tick_next = en && (cnt_q == LAST);

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Start/pause/resume/abort sequencing around a prescaled down-counter.
// Define COUNTDOWN_AUTO_RELOAD_EN for periodic mode (reload on expiry instead of DONE).
module countdown_timer_ctrl
    import countdown_timer_pkg::*;
#(
    parameter int TICK_DIV   = DEFAULT_TICK_DIV,
    parameter int TIMER_W    = DEFAULT_TIMER_W,
    parameter int INIT_VALUE = DEFAULT_INIT_VALUE
) (
    input logic                   clk,
    input logic                   reset_n,
    countdown_timer_ctrl_if.slave bus
);

    localparam logic [TIMER_W-1:0] INIT_W = TIMER_W'(INIT_VALUE);
    localparam logic [TIMER_W-1:0] ONE_W  = TIMER_W'(1);

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [TIMER_W-1:0] reload_q, reload_d;
    logic [TIMER_W-1:0] idle_timer;
    logic               tick_q, tick_d;
    logic               expired_q, expired_d;
    logic               ps_en, ps_clr, tick_next;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (ps_en),
        .clr       (ps_clr),
        .tick_next (tick_next)
    );

    // A load and a start in the same IDLE cycle start from the freshly loaded value.
    assign idle_timer = bus.load_en ? bus.load_value : timer_q;

    // NOTE: every signal driven here gets a default first, so no path leaves a
    // variable unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        reload_d  = reload_q;
        tick_d    = 1'b0;
        expired_d = 1'b0;
        ps_en     = 1'b0;
        ps_clr    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.load_en) begin
                    reload_d = bus.load_value;
                    timer_d  = bus.load_value;
                end
                if (bus.start) begin
                    ps_clr = 1'b1;
                    if (idle_timer == '0) begin
                        state_d   = ST_DONE;
                        expired_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    timer_d = reload_q;
                    ps_clr  = 1'b1;
                end else if (bus.pause) begin
                    state_d = ST_PAUSE;
                end else begin
                    ps_en = 1'b1;
                    if (tick_next && (timer_q != '0)) begin
                        tick_d  = 1'b1;
                        timer_d = timer_q - ONE_W;
                        if (timer_q == ONE_W) begin
                            expired_d = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            timer_d   = reload_q;
`else
                            state_d   = ST_DONE;
`endif
                        end
                    end
                end
            end

            ST_PAUSE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    timer_d = reload_q;
                    ps_clr  = 1'b1;
                end else if (bus.resume) begin
                    state_d = ST_RUN;
                end
            end

            ST_DONE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    timer_d = reload_q;
                    ps_clr  = 1'b1;
                end else if (bus.start) begin
                    ps_clr = 1'b1;
                    // Restarting with a zero reload value expires again immediately.
                    if (reload_q == '0) begin
                        expired_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        timer_d = reload_q;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= INIT_W;
            reload_q  <= INIT_W;
            tick_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            reload_q  <= reload_d;
            tick_q    <= tick_d;
            expired_q <= expired_d;
        end
    end

    assign bus.timer   = timer_q;
    assign bus.tick    = tick_q;
    assign bus.expired = expired_q;
    assign bus.done    = (state_q == ST_DONE);
    assign bus.state   = state_q;

endmodule
